uart_tx_cfg: RTL and testbench

Parametrised UART transmitter with a configurable frame format (data width, parity, stop bits) and an input FIFO, so producers can queue several words without waiting on each frame. It sits between the design's byte producers and the serial TX pin. It replaces the fixed 8N1 transmitter where back-to-back traffic or non-8N1 framing is needed. Frames are sent LSB first, one start bit (0), optional parity, then 1 or 2 stop bits (1).

---
 rtl/uart_tx_cfg.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable frame format (data bits, parity, stop bits)
// fed by a small word FIFO so producers can queue frames back to back.
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 61,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW   = $clog2(DATA_BITS) + 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    localparam logic [CntW-1:0]   ClkLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0]   DataLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0]   StopLast = IdxW'(STOP_BITS - 1);
    localparam logic [CountW-1:0] Full     = CountW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
    logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  frame_end_q, frame_end_d;
    logic                  pop;

    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0]     count_q, count_d;
    logic                  wr_en;
    logic                  ready_q, overflow_q;
    logic                  serial_q, serial_d;
    logic                  active_q, done_q;

    logic                  bit_end;
    logic [DATA_BITS-1:0]  head_word;

    // Write admission uses the registered count, so a full FIFO refuses even on a pop cycle.
    assign wr_en     = i_Tx_DV && (count_q != Full);
    assign bit_end   = (clk_cnt_q == ClkLast);
    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        frame_end_d = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Hold off one cycle after a frame ends so Done is issued before the next pop.
                if ((count_q != '0) && !frame_end_q) begin
                    pop       = 1'b1;
                    shift_d   = head_word;
                    parity_d  = (PARITY == 1) ? ~(^head_word) : (^head_word);
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == DataLast) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StParity: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StStop;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == StopLast) begin
                        bit_idx_d   = '0;
                        frame_end_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        serial_d = 1'b1;
        unique case (state_q)
            StStart:  serial_d = 1'b0;
            StData:   serial_d = shift_q[0];
            StParity: serial_d = parity_q;
            default:  serial_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            frame_end_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            overflow_q  <= 1'b0;
            serial_q    <= 1'b1;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            frame_end_q <= frame_end_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q     <= count_d;
            ready_q     <= (count_d != Full);
            overflow_q  <= i_Tx_DV && (count_q == Full);
            // Line-side outputs lag the state by one cycle so they stay aligned with each other.
            serial_q    <= serial_d;
            active_q    <= (state_q != StIdle);
            done_q      <= frame_end_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    assign o_Tx_Ready    = ready_q;
    assign o_Tx_Overflow = overflow_q;
    assign o_Fifo_Count  = count_q;
    assign o_Tx_Active   = active_q;
    assign o_Tx_Serial   = serial_q;
    assign o_Tx_Done     = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances cover 8N1, 7E2 and 8O1 framing,
// FIFO fill/overflow, back-to-back gaps and mid-frame reset.
module tb_uart_tx_cfg;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       dv_a = 1'b0, dv_b = 1'b0, dv_c = 1'b0;
    logic [7:0] data_a = '0, data_c = '0;
    logic [6:0] data_b = '0;
    logic       rdy_a, rdy_b, rdy_c, ovf_a, ovf_b, ovf_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;
    logic       act_a, act_b, act_c, ser_a, ser_b, ser_c, done_a, done_b, done_c;

    int n_tests = 0;
    int n_fail  = 0;
    int done_n  = 0;
    logic line_q [$];

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(data_a),
        .o_Tx_Ready(rdy_a), .o_Tx_Overflow(ovf_a), .o_Fifo_Count(cnt_a),
        .o_Tx_Active(act_a), .o_Tx_Serial(ser_a), .o_Tx_Done(done_a)
    );

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_b), .i_Tx_Byte(data_b),
        .o_Tx_Ready(rdy_b), .o_Tx_Overflow(ovf_b), .o_Fifo_Count(cnt_b),
        .o_Tx_Active(act_b), .o_Tx_Serial(ser_b), .o_Tx_Done(done_b)
    );

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_c), .i_Tx_Byte(data_c),
        .o_Tx_Ready(rdy_c), .o_Tx_Overflow(ovf_c), .o_Fifo_Count(cnt_c),
        .o_Tx_Active(act_c), .o_Tx_Serial(ser_c), .o_Tx_Done(done_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ser_of(input int w);
        if (w == 0) return ser_a;
        else if (w == 1) return ser_b;
        else return ser_c;
    endfunction

    function automatic logic act_of(input int w);
        if (w == 0) return act_a;
        else if (w == 1) return act_b;
        else return act_c;
    endfunction

    function automatic logic done_of(input int w);
        if (w == 0) return done_a;
        else if (w == 1) return done_b;
        else return done_c;
    endfunction

    // Advance one cycle on instance A, logging the line and counting Done pulses.
    task automatic step_a();
        @(negedge clk);
        line_q.push_back(ser_a);
        if (done_a) done_n++;
    endtask

    // Steps until the line is sampled low; n is the number of cycles stepped.
    task automatic wait_low(input int w, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ser_of(w) !== 1'b0 && n < budget);
    endtask

    // Entered on the first low sample of a start bit; bits[] is the frame LSB (start) first.
    task automatic frame_check(input int w, input logic [15:0] bits, input int nbits,
                               input string tag);
        logic [CPB-1:0] v;
        logic act_ok, done_seen;
        act_ok    = 1'b1;
        done_seen = 1'b0;
        v         = '0;
        for (int k = 0; k < nbits * CPB; k++) begin
            if (k != 0) @(negedge clk);
            v[k % CPB] = ser_of(w);
            act_ok     = act_ok & act_of(w);
            done_seen  = done_seen | done_of(w);
            if ((k % CPB) == CPB - 1)
                check($sformatf("%s_bit%0d", tag, k / CPB), 64'(v), 64'({CPB{bits[k / CPB]}}));
        end
        check({tag, "_active"}, 64'(act_ok), 64'd1);
        check({tag, "_no_early_done"}, 64'(done_seen), 64'd0);
    endtask

    initial begin
        int n;
        int base;
        logic [39:0] obs40, exp40;
        logic [9:0]  fr;
        logic [7:0]  words [5];
        logic        all_high;

        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ser_a", 64'(ser_a), 64'd1);
        check("rst_act_a", 64'(act_a), 64'd0);
        check("rst_done_a", 64'(done_a), 64'd0);
        check("rst_ready_a", 64'(rdy_a), 64'd1);
        check("rst_count_a", 64'(cnt_a), 64'd0);
        check("rst_ovf_a", 64'(ovf_a), 64'd0);
        check("rst_ser_b", 64'({ser_b, rdy_b, ovf_b, cnt_b}), 64'b11_0_000);
        check("rst_ser_c", 64'({ser_c, rdy_c, ovf_c, cnt_c}), 64'b11_0_000);

        // 8N1: 0xA5
        dv_a = 1'b1; data_a = 8'hA5;
        @(negedge clk);
        dv_a = 1'b0;
        check("a5_count", 64'(cnt_a), 64'd1);
        check("a5_ready", 64'(rdy_a), 64'd1);
        wait_low(0, 10, n);
        check("a5_latency", 64'(n), 64'd2);
        frame_check(0, 16'({1'b1, 8'hA5, 1'b0}), 10, "a5");
        @(negedge clk);
        check("a5_done", 64'({done_a, act_a, ser_a}), 64'b101);
        @(negedge clk);
        check("a5_done_pulse", 64'({done_a, cnt_a}), 64'd0);

        // 7 data bits, even parity, 2 stop: 0x53 has four ones -> parity 0
        dv_b = 1'b1; data_b = 7'h53;
        @(negedge clk);
        dv_b = 1'b0;
        check("b53_count", 64'(cnt_b), 64'd1);
        wait_low(1, 10, n);
        check("b53_latency", 64'(n), 64'd2);
        frame_check(1, 16'({2'b11, 1'b0, 7'h53, 1'b0}), 11, "b53");
        @(negedge clk);
        check("b53_done", 64'({done_b, act_b, ser_b}), 64'b101);

        // Odd parity, back to back: 0x00 -> parity 1, 0x07 -> parity 0
        dv_c = 1'b1; data_c = 8'h00;
        @(negedge clk);
        data_c = 8'h07;
        @(negedge clk);
        dv_c = 1'b0;
        check("c_count", 64'(cnt_c), 64'd1);
        wait_low(2, 10, n);
        check("c00_latency", 64'(n), 64'd1);
        frame_check(2, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11, "c00");
        wait_low(2, 10, n);
        check("c_gap", 64'(n), 64'd3);
        frame_check(2, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, "c07");
        @(negedge clk);
        check("c07_done", 64'({done_c, act_c, ser_c, cnt_c}), 64'b101_000);

        // FIFO fill, write+pop on the same cycle, overflow, five frames back to back
        line_q.delete();
        done_n = 0;
        dv_a = 1'b1; data_a = words[0];
        step_a();
        check("fifo_cnt1", 64'(cnt_a), 64'd1);
        data_a = words[1];
        step_a();
        check("wr_pop_same", 64'(cnt_a), 64'd1);
        data_a = words[2];
        step_a();
        check("fifo_cnt2", 64'(cnt_a), 64'd2);
        data_a = words[3];
        step_a();
        check("fifo_cnt3", 64'(cnt_a), 64'd3);
        data_a = words[4];
        step_a();
        check("fifo_full", 64'({cnt_a, rdy_a, ovf_a}), 64'b100_0_0);
        data_a = 8'h66;
        step_a();
        check("fifo_ovf", 64'({cnt_a, rdy_a, ovf_a}), 64'b100_0_1);
        dv_a = 1'b0;
        step_a();
        check("fifo_ovf_pulse", 64'({cnt_a, ovf_a}), 64'b100_0);
        repeat (219) step_a();
        check("fifo_latency", 64'({line_q[0], line_q[1], line_q[2]}), 64'b110);
        for (int f = 0; f < 5; f++) begin
            base = 2 + f * 42;
            fr   = {1'b1, words[f], 1'b0};
            for (int k = 0; k < 40; k++) begin
                obs40[k] = line_q[base + k];
                exp40[k] = fr[k / 4];
            end
            check($sformatf("fifo_frame%0d", f), 64'(obs40), 64'(exp40));
            check($sformatf("fifo_gap%0d", f),
                  64'({line_q[base + 40], line_q[base + 41]}), 64'b11);
        end
        all_high = 1'b1;
        for (int i = 212; i < 226; i++) all_high = all_high & line_q[i];
        check("fifo_no_sixth", 64'(all_high), 64'd1);
        check("fifo_done_count", 64'(done_n), 64'd5);
        check("fifo_drained", 64'({cnt_a, rdy_a}), 64'b000_1);

        // Reset in the middle of 0x3C's data bits with two words queued
        dv_a = 1'b1; data_a = 8'h3C;
        step_a();
        data_a = 8'h01;
        step_a();
        data_a = 8'h02;
        step_a();
        dv_a = 1'b0;
        check("rst_mid_queued", 64'(cnt_a), 64'd2);
        repeat (5) step_a();
        check("rst_mid_inflight", 64'(act_a), 64'd1);
        rst = 1'b1;
        step_a();
        rst = 1'b0;
        check("rst_mid_line", 64'({ser_a, act_a, cnt_a, done_a, rdy_a}), 64'b1_0_000_0_1);
        line_q.delete();
        done_n = 0;
        repeat (80) step_a();
        all_high = 1'b1;
        for (int i = 0; i < 80; i++) all_high = all_high & line_q[i];
        check("rst_mid_quiet", 64'(all_high), 64'd1);
        check("rst_mid_no_done", 64'(done_n), 64'd0);
        check("rst_mid_count", 64'({cnt_a, act_a}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
